// File: rtl/tdisplay_scan_ctrl_if.sv
// Handshake/data bundle between tdisplay, the scan controller and the board pins.
// master = converter/board side, slave = scan controller.
interface tdisplay_scan_ctrl_if;
  logic       en;
  logic       bcd_valid;
  logic       sign;
  logic [3:0] thousands;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       c_f;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       snap_ack;
  logic       frame_done;

  modport master (
    output en, bcd_valid, sign, thousands, hundreds, tens, ones, c_f,
    input  an, seg, dp, snap_ack, frame_done
  );

  modport slave (
    input  en, bcd_valid, sign, thousands, hundreds, tens, ones, c_f,
    output an, seg, dp, snap_ack, frame_done
  );
endinterface

// File: rtl/tdisplay_scan_ctrl.sv
// 8-digit seven-segment scan controller; a new reading is latched only at the
// 7->0 slot wrap so a frame never mixes old and new digits.
module tdisplay_scan_ctrl #(
  parameter int DIV = 100000
) (
  input logic                 clk,
  input logic                 rst_n,
  tdisplay_scan_ctrl_if.slave bus
);
  localparam int              CW      = $clog2(DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  typedef struct packed {
    logic       sign;
    logic [3:0] th;
    logic [3:0] hu;
    logic [3:0] te;
    logic [3:0] on;
    logic       cf;
  } snap_t;

  function automatic logic [6:0] bcd2seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          pend_q, pend_d;
  snap_t         snap_q, snap_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          ack_q, ack_d;
  logic          fd_q, fd_d;

  logic tick, wrap, take;

  // A bcd_valid arriving on the wrap tick itself counts as pending, so its
  // data is captured immediately rather than waiting a whole frame.
  always_comb begin
    tick   = bus.en && (cnt_q == CNT_MAX);
    wrap   = tick && (idx_q == 3'd7);
    take   = wrap && (pend_q || bus.bcd_valid);

    cnt_d  = cnt_q;
    idx_d  = idx_q;
    if (bus.en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) idx_d = idx_q + 3'd1;
    end

    pend_d = take ? 1'b0 : (pend_q || bus.bcd_valid);

    snap_d = snap_q;
    if (take) begin
      snap_d.sign = bus.sign;
      snap_d.th   = bus.thousands;
      snap_d.hu   = bus.hundreds;
      snap_d.te   = bus.tens;
      snap_d.on   = bus.ones;
      snap_d.cf   = bus.c_f;
    end

    ack_d = take;
    fd_d  = wrap;
  end

  // Output stage: decode the current slot from the latched snapshot only.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (bus.en) begin
      an_d = ~(8'b1 << idx_q);
      dp_d = (idx_q != 3'd2);
      case (idx_q)
        3'd5:    seg_d = snap_q.sign ? SEG_DASH : SEG_BLANK;
        3'd4:    seg_d = (snap_q.th == 4'd0) ? SEG_BLANK : bcd2seg(snap_q.th);
        3'd3:    seg_d = (snap_q.th == 4'd0 && snap_q.hu == 4'd0) ? SEG_BLANK
                                                                   : bcd2seg(snap_q.hu);
        3'd2:    seg_d = bcd2seg(snap_q.te);
        3'd1:    seg_d = bcd2seg(snap_q.on);
        3'd0:    seg_d = snap_q.cf ? SEG_F : SEG_C;
        default: seg_d = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      snap_q <= '0;
      an_q   <= 8'hFF;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      ack_q  <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      ack_q  <= ack_d;
      fd_q   <= fd_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.snap_ack   = ack_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_tdisplay_scan_ctrl.sv
// Randomised bench for tdisplay_scan_ctrl against a character-level display model.
module tb_tdisplay_scan_ctrl;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdisplay_scan_ctrl_if vif();
  tdisplay_scan_ctrl #(.DIV(DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(vif));

  int n_chk = 0;
  int n_err = 0;

  // model: slot position, pending reading, displayed reading
  int         m_cnt, m_idx;
  bit         m_pend;
  bit         m_sign, m_cf;
  logic [3:0] m_th, m_hu, m_te, m_on;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_ack, e_fd;
  int         n_fd, n_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input byte c);
    case (c)
      "0": return 7'b1000000;
      "1": return 7'b1111001;
      "2": return 7'b0100100;
      "3": return 7'b0110000;
      "4": return 7'b0011001;
      "5": return 7'b0010010;
      "6": return 7'b0000010;
      "7": return 7'b1111000;
      "8": return 7'b0000000;
      "9": return 7'b0010000;
      "-": return 7'b0111111;
      "C": return 7'b1000110;
      "F": return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic byte dchar(input logic [3:0] d);
    return (d <= 4'd9) ? byte'(8'd48 + {4'd0, d}) : byte'(8'h20);
  endfunction

  // Character shown on a slot given the displayed reading (slot 7 leftmost).
  function automatic byte slot_char(input int s);
    case (s)
      5: return m_sign ? byte'("-") : byte'(" ");
      4: return (m_th == 0) ? byte'(" ") : dchar(m_th);
      3: return (m_th == 0 && m_hu == 0) ? byte'(" ") : dchar(m_hu);
      2: return dchar(m_te);
      1: return dchar(m_on);
      0: return m_cf ? byte'("F") : byte'("C");
      default: return byte'(" ");
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_pend = 0;
    m_sign = 0; m_cf = 0; m_th = 0; m_hu = 0; m_te = 0; m_on = 0;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1; e_ack = 0; e_fd = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit slot_end, frame_end, latch;
    slot_end  = vif.en && (m_cnt == DIV - 1);
    frame_end = slot_end && (m_idx == 7);
    latch     = frame_end && (m_pend || vif.bcd_valid);
    if (vif.en) begin
      e_an  = 8'hFF ^ (8'(1) << m_idx);
      e_seg = glyph(slot_char(m_idx));
      e_dp  = (m_idx == 2) ? 1'b0 : 1'b1;
    end else begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1;
    end
    e_fd  = frame_end;
    e_ack = latch;
    if (latch) begin
      m_sign = vif.sign; m_th = vif.thousands; m_hu = vif.hundreds;
      m_te = vif.tens; m_on = vif.ones; m_cf = vif.c_f;
    end
    m_pend = latch ? 1'b0 : (m_pend || vif.bcd_valid);
    if (vif.en) begin
      m_cnt = (m_cnt + 1) % DIV;
      if (slot_end) m_idx = (m_idx + 1) % 8;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".an"},  32'(vif.an),         32'(e_an));
    chk({tag, ".seg"}, 32'(vif.seg),        32'(e_seg));
    chk({tag, ".dp"},  32'(vif.dp),         32'(e_dp));
    chk({tag, ".ack"}, 32'(vif.snap_ack),   32'(e_ack));
    chk({tag, ".fd"},  32'(vif.frame_done), 32'(e_fd));
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outs(tag);
    if (vif.frame_done) n_fd++;
    if (vif.snap_ack)   n_ack++;
    vif.bcd_valid = 0;
  endtask

  task automatic cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic reading(input bit s, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d, input bit f);
    vif.sign = s; vif.thousands = a; vif.hundreds = b; vif.tens = c; vif.ones = d;
    vif.c_f = f; vif.bcd_valid = 1;
  endtask

  task automatic goto_slot(input string tag, input int idx, input int cnt);
    int guard = 0;
    while (!(m_idx == idx && m_cnt == cnt) && guard < 64) begin
      cyc(tag);
      guard++;
    end
    if (guard >= 64) chk({tag, ".timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    vif.en = 1; vif.bcd_valid = 0; vif.sign = 0; vif.c_f = 0;
    vif.thousands = 0; vif.hundreds = 0; vif.tens = 0; vif.ones = 0;
    n_fd = 0; n_ack = 0;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outs("rst");
    rst_n = 1;

    // idle frame after reset: blanks with 'C' on slot 0
    cycles("idle", 40);

    // mid-frame reading 0025 C, shown from the next wrap onwards
    goto_slot("hs", 3, 1);
    reading(0, 4'd0, 4'd0, 4'd2, 4'd5, 0);
    cycles("hs", 70);

    // negative Fahrenheit 0104
    goto_slot("neg", 2, 0);
    reading(1, 4'd0, 4'd1, 4'd0, 4'd4, 1);
    cycles("neg", 70);

    // three frames with nothing pending
    n_fd = 0; n_ack = 0;
    vif.thousands = 4'd7; vif.hundreds = 4'd7; vif.tens = 4'd7; vif.ones = 4'd7;
    cycles("nopend", 3 * 8 * DIV);
    chk("nopend.fd_count",  32'(n_fd),  32'd3);
    chk("nopend.ack_count", 32'(n_ack), 32'd0);

    // bcd_valid on the wrap tick itself, with invalid BCD on ones
    goto_slot("bnd", 7, DIV - 1);
    reading(0, 4'd1, 4'd2, 4'd3, 4'hC, 0);
    n_ack = 0;
    cycles("bnd", 8 * DIV + 4);
    chk("bnd.ack_count", 32'(n_ack), 32'd1);

    // disable at slot 3, queue a reading while disabled, resume
    goto_slot("en", 3, 1);
    vif.en = 0;
    cycles("dis", 5);
    reading(1, 4'd0, 4'd0, 4'd0, 4'd9, 1);
    cycles("dis", 6);
    vif.en = 1;
    cycles("resume", 80);

    // randomised traffic
    for (int i = 0; i < 1500; i++) begin
      vif.en = ($urandom_range(0, 9) != 0);
      vif.sign = 1'($urandom); vif.c_f = 1'($urandom);
      vif.thousands = 4'($urandom_range(0, 15)); vif.hundreds = 4'($urandom_range(0, 15));
      vif.tens = 4'($urandom_range(0, 15)); vif.ones = 4'($urandom_range(0, 15));
      vif.bcd_valid = ($urandom_range(0, 15) == 0);
      cyc("rnd");
    end
    vif.en = 1;

    // reset at slot 5 with a reading pending: it must be discarded
    goto_slot("mrst", 2, 2);
    reading(1, 4'd8, 4'd8, 4'd8, 4'd8, 1);
    cyc("mrst");
    goto_slot("mrst", 5, 1);
    rst_n = 0;
    #1;
    model_reset();
    check_outs("mrst.async");
    @(posedge clk);
    #1;
    check_outs("mrst.hold");
    rst_n = 1;
    n_ack = 0;
    cycles("mrst.after", 8 * DIV * 2 + 2);
    chk("mrst.ack_count", 32'(n_ack), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tdisplay_scan_ctrl.md
Name: tdisplay_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit common-anode seven-segment display, fed by the tdisplay BCD conversion outputs. It latches a converted reading only at frame boundaries, so a frame never shows a mix of old and new digits. Each scan slot drives one digit with sign, leading-zero blanking, decimal point and unit letter. It sits between tdisplay and the board anode/segment pins.

Parameters:
DIV, 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); must be >= 2; benches use 4.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
en  input  1  display enable; 0 blanks the display and freezes the scan
bcd_valid  input  1  one-cycle pulse: sign/thousands/hundreds/tens/ones/c_f hold a new conversion
sign  input  1  1 = negative reading
thousands  input  4  BCD hundreds-of-degrees digit
hundreds  input  4  BCD tens-of-degrees digit
tens  input  4  BCD units-of-degrees digit
ones  input  4  BCD tenths digit
c_f  input  1  0 = Celsius, 1 = Fahrenheit
an  output  8  anode enables, active-low; an[7] is the leftmost digit
seg  output  7  {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
snap_ack  output  1  one-cycle pulse when a pending reading is latched
frame_done  output  1  one-cycle pulse at each 7->0 slot wrap

Behaviour:
- Reset (async, rst_n=0): prescaler=0, idx=0, pending=0, snapshot regs all 0 (c_f=0), an=8'hFF, seg=7'h7F, dp=1, snap_ack=0, frame_done=0. Reset mid-frame aborts the scan immediately and discards the pending flag.
- Prescaler: counts 0..DIV-1 while en=1. tick = (count==DIV-1 && en). On tick, count->0 and idx->idx+1 mod 8.
- Pending: set on bcd_valid. Cleared only by a snapshot.
- Snapshot: occurs on a tick with idx==7 and pending=1. It copies the current inputs into the snapshot regs, clears pending and pulses snap_ack in the next cycle.
- Same-cycle snapshot and bcd_valid: the snapshot takes the current inputs and pending ends 0.
- frame_done pulses in the cycle after every tick with idx==7, whether or not a snapshot occurs.
- Outputs are registered, with one-cycle latency from idx/snapshot to an/seg/dp. an = ~(1<<idx) while en=1.
- Digit map (idx -> content):
  - 7, 6: blank.
  - 5: '-' if sign, else blank.
  - 4: thousands, blanked if 0.
  - 3: hundreds, blanked if 0 and thousands==0.
  - 2: tens, always shown; dp=0 on this slot only.
  - 1: ones.
  - 0: 'C' or 'F' per c_f.
- Segment codes:
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Symbols: '-'=0111111, blank=1111111, C=1000110, F=0001110.
  - BCD 10..15 displays blank (no X propagation).
- en=0: prescaler and idx hold their values, no ticks, no snapshot, no frame_done. an=8'hFF and seg=7'h7F the next cycle. Pending still accumulates. Re-enable resumes from the held idx and count.
- Snapshot regs are read only by the output stage. Inputs changing without bcd_valid never affect the display.

Test Plan:
- Reset/idle: rst_n=0 then 1, en=1, DIV=4 -> an=8'hFF, seg=7'h7F during reset; first cycle after release an=8'b11111110, seg=1000110 ('C'); frame_done every 32 cycles.
- Snapshot handshake: mid-frame bcd_valid with sign=0, digits 0,0,2,5, c_f=0 -> display unchanged until the idx 7->0 tick; snap_ack one cycle later; next frame shows slots 4,3 blank, slot 2 '2' with dp=0, slot 1 '5', slot 0 'C'.
- Negative/Fahrenheit: bcd_valid with sign=1, digits 0,1,0,4, c_f=1 -> slot 5 seg=0111111, slot 3 '1', slot 2 '0' (shown, dp=0), slot 1 '4', slot 0 'F'.
- No pending: run 3 frames with no bcd_valid -> snap_ack never asserts; frame_done pulses exactly 3 times.
- Boundary: bcd_valid in the same cycle as the idx==7 tick -> inputs from that cycle captured, pending=0, no snapshot in the following frame. Invalid BCD 4'hC on ones -> slot 1 seg=1111111.
- Enable/reset mid-operation: en=0 at idx=3 -> an=8'hFF next cycle, idx holds; bcd_valid while disabled then en=1 -> scan resumes at idx=3 and the snapshot occurs at the next wrap. rst_n pulsed low at idx=5 -> outputs reset immediately, pending cleared.
